coin_beam_detector: RTL and testbench
=====================================

Name: coin_beam_detector

Overview:
- Parametrised successor to the four-coin beam-break front end. It handles NUM_CH beam sensors, each with a counter-based debouncer and its own FSM.
- Each channel has a sticky "coin seen" flag that the processor clears through its own bit of acknowledgeBeam.
- Each channel keeps a saturating coin count. All counts clear together on a processor command.
- Sits between the raw IR beam inputs and the processor's memory-mapped I/O.

Parameters:
- NUM_CH, 4, number of beam channels; legal range 1..31.
- DEBOUNCE_CYCLES, 50000, consecutive stable synchronised samples required to accept a level change; must be ≥ 2.
- CNT_W, 16, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- COUNT_W, 16, width of each per-channel coin count.
- COIN_VALUES, {8'd25,8'd10,8'd5,8'd1}, packed 8-bit value per channel with channel 0 in the LSB. Used only with COIN_TOTAL_EN.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- reading  input  NUM_CH  raw beam sensor levels, asynchronous; 1 = beam broken.
- acknowledgeBeam  input  32  processor command word. Bit i (i < NUM_CH) clears beamBroken[i]. Bit 31 clears all counts and overflow.
- beamBroken  output  NUM_CH  sticky per-channel coin event flag.
- coinCount  output  NUM_CH*COUNT_W  per-channel counts; channel i occupies [i*COUNT_W +: COUNT_W].
- overflow  output  1  sticky; set when any count saturates.
- LED  output  NUM_CH  1 while channel i's debounced beam is broken (FSM in HELD or RELEASING).

Behaviour:
- Reset: all outputs 0, all FSMs IDLE, debounce counters 0, synchronisers 0. Reset is synchronous only; there is no asynchronous path.
- Input path: each reading[i] passes through a 2-flop synchroniser, giving sync[i] two cycles after the raw input.
- Per-channel FSM, one debounce counter each:
  - IDLE: counter 0. If sync = 1, go to ARMING with counter = 1.
  - ARMING: if sync = 1, increment the counter. When the counter reaches DEBOUNCE_CYCLES, go to HELD and fire the event. If sync = 0, return to IDLE with counter 0; no event.
  - HELD: counter 0. If sync = 0, go to RELEASING with counter = 1.
  - RELEASING: if sync = 0, increment the counter. When it reaches DEBOUNCE_CYCLES, go to IDLE. If sync = 1, return to HELD; no new event.
- Event: exactly one per accepted broken period. On the cycle the FSM enters HELD:
  - beamBroken[i] is set and coinCount[i] increments.
  - Both outputs are visible the following cycle.
  - Latency from a raw rising edge held stable is 2 + DEBOUNCE_CYCLES cycles to the FSM transition, plus 1 cycle to the outputs.
- Acknowledge: acknowledgeBeam[i] = 1 clears beamBroken[i] on the next edge. Level-sensitive: while the bit is held, the flag stays clear, except as below.
  - Event and ack for the same channel in the same cycle: set wins (flag = 1) and the count still increments. No event is lost.
  - acknowledgeBeam bits NUM_CH..30 are ignored.
- Clear (acknowledgeBeam[31] = 1): all coinCount := 0 and overflow := 0 on the next edge.
  - Clear and event in the same cycle: that channel's count becomes 1.
  - Clear does not affect beamBroken, FSMs or LED.
- Saturation: a count at 2^COUNT_W-1 holds its value on further events and sets overflow. beamBroken still sets.
- Channels are fully independent; simultaneous events on several channels are all counted.
- Reset mid-operation: all state is discarded. A beam still broken when reset falls is treated as a new break and produces an event after full debounce.

Optional Feature:
- Macro: COIN_TOTAL_EN.
- Defined: adds output totalValue [31:0], reset 0.
  - On each cycle, totalValue increases by the sum of COIN_VALUES[i] over every channel firing an event that cycle. Multiple channels firing together are summed in one cycle.
  - Updates with the same 1-cycle output timing as coinCount.
  - Wraps modulo 2^32 and does not affect overflow. Cleared by acknowledgeBeam[31]; clear and events in the same cycle give the sum of those events.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan (bench with DEBOUNCE_CYCLES=4, NUM_CH=4, COUNT_W=4):
- reading[0] high for 20 cycles, then low: exactly one event. beamBroken[0] = 1 at 7 cycles after the raw edge, coinCount ch0 = 1. LED[0] high from the event until 4 stable low sync cycles have elapsed.
- reading[1] pulses high for 3 cycles, then a 1-cycle low glitch inside a held break on ch1: no event from the short pulse, and no second event from the glitch. Final count ch1 = 1.
- Event on ch2 in the same cycle as acknowledgeBeam = 32'h4: beamBroken[2] remains 1. A later ack-only cycle clears it to 0.
- 16 events on ch3: coinCount ch3 = 15 and overflow = 1. Then acknowledgeBeam = 32'h8000_0000: all counts 0 and overflow 0; beamBroken unchanged.
- Simultaneous events on ch0..3 with COIN_TOTAL_EN: all four counts increment and totalValue increases by 41 in one cycle.
- Assert reset during ARMING on ch0 with reading held high: outputs 0. After release, one event is produced 2+4 cycles after the first post-reset sample.

Source files
------------

// File: rtl/coin_beam_detector.sv
// coin_beam_detector: debounced multi-channel coin beam front end with sticky flags and saturating counts.
// Define COIN_TOTAL_EN to add the running totalValue output weighted by COIN_VALUES.
module coin_beam_detector #(
    parameter int NUM_CH = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W = 16,
    parameter int COUNT_W = 16,
    parameter logic [8*NUM_CH-1:0] COIN_VALUES = {8'd25, 8'd10, 8'd5, 8'd1}
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         reading,
    input  logic [31:0]               acknowledgeBeam,
    output logic [NUM_CH-1:0]         beamBroken,
    output logic [NUM_CH*COUNT_W-1:0] coinCount,
    output logic                      overflow,
    output logic [NUM_CH-1:0]         LED
`ifdef COIN_TOTAL_EN
    ,
    output logic [31:0]               totalValue
`endif
);
    typedef enum logic [1:0] {IDLE, ARMING, HELD, RELEASING} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] MAX = '1;
    state_t st [NUM_CH];
    state_t st_n [NUM_CH];
    logic [CNT_W-1:0] cnt [NUM_CH];
    logic [CNT_W-1:0] cnt_n [NUM_CH];
    logic [NUM_CH-1:0] s1, s2, fire, ev, at_max;
    logic clr, ack_unused;
    assign clr = acknowledgeBeam[31];
    assign ack_unused = ^acknowledgeBeam;
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            ev <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                st[i] <= IDLE;
                cnt[i] <= '0;
            end
        end else begin
            s1 <= reading;
            s2 <= s1;
            ev <= fire;
            for (int i = 0; i < NUM_CH; i++) begin
                st[i] <= st_n[i];
                cnt[i] <= cnt_n[i];
            end
        end
    end
    // The D-th consecutive stable sample is the one that completes the level change.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            st_n[i] = st[i];
            cnt_n[i] = '0;
            case (st[i])
                IDLE: if (s2[i]) begin
                    st_n[i] = ARMING;
                    cnt_n[i] = CNT_W'(1);
                end
                ARMING: if (!s2[i]) st_n[i] = IDLE;
                    else if (cnt[i] == LAST) st_n[i] = HELD;
                    else cnt_n[i] = cnt[i] + 1'b1;
                HELD: if (!s2[i]) begin
                    st_n[i] = RELEASING;
                    cnt_n[i] = CNT_W'(1);
                end
                default: if (s2[i]) st_n[i] = HELD;
                    else if (cnt[i] == LAST) st_n[i] = IDLE;
                    else cnt_n[i] = cnt[i] + 1'b1;
            endcase
        end
    end
    always_comb begin
        fire = '0;
        LED = '0;
        at_max = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            fire[i] = st[i] == ARMING && s2[i] && cnt[i] == LAST;
            LED[i] = st[i] == HELD || st[i] == RELEASING;
            at_max[i] = coinCount[i*COUNT_W +: COUNT_W] == MAX;
        end
    end
    // A new event beats a same-cycle acknowledge, and a clear still counts that event.
    always_ff @(posedge clock) begin
        if (reset) begin
            beamBroken <= '0;
            coinCount <= '0;
            overflow <= 1'b0;
        end else begin
            beamBroken <= ev | (beamBroken & ~acknowledgeBeam[NUM_CH-1:0]);
            overflow <= !clr && (overflow || |(ev & at_max));
            for (int i = 0; i < NUM_CH; i++)
                coinCount[i*COUNT_W +: COUNT_W] <= clr ? COUNT_W'(ev[i])
                    : coinCount[i*COUNT_W +: COUNT_W] + COUNT_W'(ev[i] && !at_max[i]);
        end
    end
`ifdef COIN_TOTAL_EN
    logic [31:0] ev_sum;
    always_comb begin
        ev_sum = '0;
        for (int i = 0; i < NUM_CH; i++)
            ev_sum = ev_sum + (ev[i] ? 32'(COIN_VALUES[8*i +: 8]) : 32'd0);
    end
    always_ff @(posedge clock) begin
        if (reset) totalValue <= '0;
        else totalValue <= (clr ? 32'd0 : totalValue) + ev_sum;
    end
`endif
endmodule

// File: tb/tb_coin_beam_detector.sv
// tb_coin_beam_detector: scoreboard bench for coin_beam_detector with a run-length debounce reference model.
module tb_coin_beam_detector;
    localparam int N = 4;
    localparam int D = 4;
    localparam int CW = 4;
    localparam int VAL [N] = '{1, 5, 10, 25};
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] reading = '0;
    logic [31:0] ack = '0;
    logic [N-1:0] beamBroken, LED;
    logic [N*CW-1:0] coinCount;
    logic overflow;
`ifdef COIN_TOTAL_EN
    logic [31:0] totalValue;
`endif
    int vectors = 0;
    int miscompares = 0;

    coin_beam_detector #(.NUM_CH(N), .DEBOUNCE_CYCLES(D), .CNT_W(4), .COUNT_W(CW)) dut (
        .clock(clock), .reset(reset), .reading(reading), .acknowledgeBeam(ack),
        .beamBroken(beamBroken), .coinCount(coinCount), .overflow(overflow), .LED(LED)
`ifdef COIN_TOTAL_EN
        , .totalValue(totalValue)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [N-1:0] bb;
        logic [N*CW-1:0] cnt;
        logic ovf;
        logic [N-1:0] led;
        logic [31:0] tot;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a channel's accepted level flips after D consecutive synchronised samples that disagree with it.
    int m_s1 [N], m_s2 [N], lvl [N], run [N], mev [N], m_cnt [N];
    logic [N-1:0] m_bb;
    logic m_ovf;
    logic [31:0] m_tot;
    always @(posedge clock) begin : model
        exp_t e;
        logic [31:0] sum;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; lvl[i] = 0; run[i] = 0; mev[i] = 0; m_cnt[i] = 0;
            end
            m_bb = '0; m_ovf = 1'b0; m_tot = '0;
        end else begin
            sum = '0;
            if (ack[31]) m_ovf = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (mev[i] != 0) begin
                    m_bb[i] = 1'b1;
                    sum = sum + VAL[i];
                end else if (ack[i]) m_bb[i] = 1'b0;
                if (ack[31]) m_cnt[i] = mev[i];
                else if (mev[i] != 0) begin
                    if (m_cnt[i] == 2**CW - 1) m_ovf = 1'b1;
                    else m_cnt[i]++;
                end
            end
            m_tot = ack[31] ? sum : m_tot + sum;
            for (int i = 0; i < N; i++) begin
                mev[i] = 0;
                if (m_s2[i] != lvl[i]) begin
                    run[i]++;
                    if (run[i] == D) begin
                        lvl[i] = m_s2[i];
                        run[i] = 0;
                        mev[i] = m_s2[i];
                    end
                end else run[i] = 0;
                m_s2[i] = m_s1[i];
                m_s1[i] = int'(reading[i]);
            end
        end
        for (int i = 0; i < N; i++) begin
            e.cnt[i*CW +: CW] = CW'(m_cnt[i]);
            e.led[i] = lvl[i] != 0;
        end
        e.bb = m_bb;
        e.ovf = m_ovf;
        e.tot = m_tot;
        q.push_back(e);
    end

    always @(negedge clock) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("beamBroken", 64'(beamBroken), 64'(e.bb));
            chk("coinCount", 64'(coinCount), 64'(e.cnt));
            chk("overflow", 64'(overflow), 64'(e.ovf));
            chk("LED", 64'(LED), 64'(e.led));
`ifdef COIN_TOTAL_EN
            chk("totalValue", 64'(totalValue), 64'(e.tot));
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        logic [N-1:0] bb_before;
        int hold [N];
        tick(3);
        reset = 1'b0;
        tick(2);
        reading[0] = 1'b1;
        tick(6);
        chk("ch0_not_yet", 64'(beamBroken[0]), 64'd0);
        tick(1);
        chk("ch0_event_at_7", 64'(beamBroken[0]), 64'd1);
        chk("ch0_count", 64'(coinCount[3:0]), 64'd1);
        tick(13);
        reading[0] = 1'b0;
        tick(12);
        chk("ch0_led_off", 64'(LED[0]), 64'd0);
        chk("ch0_single_event", 64'(coinCount[3:0]), 64'd1);
        reading[1] = 1'b1; tick(3);
        reading[1] = 1'b0; tick(8);
        chk("ch1_short_pulse", 64'(coinCount[7:4]), 64'd0);
        reading[1] = 1'b1; tick(10);
        reading[1] = 1'b0; tick(1);
        reading[1] = 1'b1; tick(6);
        reading[1] = 1'b0; tick(12);
        chk("ch1_glitch", 64'(coinCount[7:4]), 64'd1);
        reading[2] = 1'b1;
        tick(6);
        ack = 32'h4;
        tick(1);
        chk("ch2_set_wins", 64'(beamBroken[2]), 64'd1);
        ack = '0; tick(2);
        ack = 32'h4; tick(1);
        chk("ch2_ack_clears", 64'(beamBroken[2]), 64'd0);
        ack = '0;
        reading[2] = 1'b0; tick(12);
        for (int k = 0; k < 16; k++) begin
            reading[3] = 1'b1; tick(8);
            reading[3] = 1'b0; tick(8);
        end
        chk("ch3_saturated", 64'(coinCount[15:12]), 64'd15);
        chk("ch3_overflow", 64'(overflow), 64'd1);
        bb_before = 4'b1011;
        ack = 32'h8000_0000; tick(1);
        ack = '0;
        chk("clear_counts", 64'(coinCount), 64'd0);
        chk("clear_overflow", 64'(overflow), 64'd0);
        chk("clear_keeps_flags", 64'(beamBroken), 64'(bb_before));
        reading = 4'hf; tick(10);
        chk("all_four_counts", 64'(coinCount), 64'h1111);
`ifdef COIN_TOTAL_EN
        chk("total_41", 64'(totalValue), 64'd41);
`endif
        reading = '0; tick(10);
        reading[0] = 1'b1; tick(4);
        reset = 1'b1; tick(2);
        chk("reset_flags", 64'(beamBroken), 64'd0);
        chk("reset_counts", 64'(coinCount), 64'd0);
        chk("reset_led", 64'(LED), 64'd0);
        reset = 1'b0; tick(6);
        chk("post_reset_pending", 64'(coinCount[3:0]), 64'd0);
        tick(1);
        chk("post_reset_event", 64'(coinCount[3:0]), 64'd1);
        tick(5);
        reading = '0; tick(10);
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    reading[i] = ~reading[i];
                    hold[i] = $urandom_range(1, 12);
                end else hold[i]--;
            end
            ack = ($urandom_range(0, 3) == 0) ? {($urandom_range(0, 15) == 0), 27'd0, 4'($urandom)} : 32'd0;
            reset = $urandom_range(0, 299) == 0;
            tick(1);
        end
        reset = 1'b0; ack = '0; reading = '0;
        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
